minhash_min_accum: RTL and testbench

MINHASH_MIN_ACCUM -- requirements
Module: minhash_min_accum

---
 rtl/proj_pkg.sv | 10 +
 rtl/minhash_min_accum.sv | 111 +++++++++++
 tb/tb_minhash_min_accum.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// Shared types and default sizing for the MinHash datapath.
package proj_pkg;
    localparam int HASHER_DATA_BITS = 32;
    localparam int NUM_HASHES       = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;
endpackage

// File: rtl/minhash_min_accum.sv
// Keeps the running unsigned minimum signature per hash seed over a sequence
// of k-mers, then streams one result beat per seed.
module minhash_min_accum
    import proj_pkg::*;
#(
    parameter int HASHER_DATA_BITS = proj_pkg::HASHER_DATA_BITS,
    parameter int NUM_HASHES       = proj_pkg::NUM_HASHES,
    localparam int IDX_BITS = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [HASHER_DATA_BITS-1:0] in_signature,
    input  logic [IDX_BITS-1:0]         in_hash_idx,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [HASHER_DATA_BITS-1:0] out_min,
    output logic [IDX_BITS-1:0]         out_hash_idx,
    output logic                        out_last,
    output logic                        idx_err
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_HASHES - 1);

    state_t                        state_q, state_d;
    logic [IDX_BITS-1:0]           exp_idx_q, exp_idx_d;
    logic [IDX_BITS-1:0]           dump_cnt_q, dump_cnt_d;
    logic                          first_kmer_q, first_kmer_d;
    logic                          idx_err_q, idx_err_d;
    logic [HASHER_DATA_BITS-1:0]   min_q [NUM_HASHES];
    logic                          wr_en;
    logic [HASHER_DATA_BITS-1:0]   wr_data;
    logic [HASHER_DATA_BITS-1:0]   cur_min;
    logic                          accept;

    assign accept  = in_valid && (state_q == ACCUM);
    // A write only happens when in_hash_idx == exp_idx, so exp_idx addresses it.
    assign cur_min = min_q[exp_idx_q];

    always_comb begin
        state_d      = state_q;
        exp_idx_d    = exp_idx_q;
        dump_cnt_d   = dump_cnt_q;
        first_kmer_d = first_kmer_q;
        idx_err_d    = idx_err_q;
        wr_en        = 1'b0;
        wr_data      = cur_min;

        if (accept) begin
            if (in_hash_idx != exp_idx_q) begin
                idx_err_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (first_kmer_q || (in_signature < cur_min)) begin
                    wr_data = in_signature;
                end
                if (exp_idx_q == LAST_IDX) begin
                    exp_idx_d    = '0;
                    first_kmer_d = 1'b0;
                    if (in_last) begin
                        state_d = DUMP;
                    end
                end else begin
                    exp_idx_d = exp_idx_q + 1'b1;
                end
            end
        end

        if ((state_q == DUMP) && out_ready) begin
            if (dump_cnt_q == LAST_IDX) begin
                dump_cnt_d   = '0;
                first_kmer_d = 1'b1;
                state_d      = ACCUM;
            end else begin
                dump_cnt_d = dump_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            exp_idx_q    <= '0;
            dump_cnt_q   <= '0;
            first_kmer_q <= 1'b1;
            idx_err_q    <= 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                min_q[i] <= '1;
            end
        end else begin
            state_q      <= state_d;
            exp_idx_q    <= exp_idx_d;
            dump_cnt_q   <= dump_cnt_d;
            first_kmer_q <= first_kmer_d;
            idx_err_q    <= idx_err_d;
            if (wr_en) begin
                min_q[exp_idx_q] <= wr_data;
            end
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DUMP);
    assign out_min      = min_q[dump_cnt_q];
    assign out_hash_idx = dump_cnt_q;
    assign out_last     = (state_q == DUMP) && (dump_cnt_q == LAST_IDX);
    assign idx_err      = idx_err_q;

endmodule

// File: tb/tb_minhash_min_accum.sv
// Directed self-checking bench for minhash_min_accum with four hash seeds.
module tb_minhash_min_accum;

    localparam int W = 32;
    localparam int N = 4;
    localparam int IB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_signature;
    logic [IB-1:0] in_hash_idx;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_min;
    logic [IB-1:0] out_hash_idx;
    logic          out_last;
    logic          idx_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    minhash_min_accum #(
        .HASHER_DATA_BITS(W),
        .NUM_HASHES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_signature(in_signature),
        .in_hash_idx(in_hash_idx),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_min(out_min),
        .out_hash_idx(out_hash_idx),
        .out_last(out_last),
        .idx_err(idx_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IB-1:0] idx, input logic [W-1:0] sig,
                             input logic last);
        in_valid     = 1'b1;
        in_hash_idx  = idx;
        in_signature = sig;
        in_last      = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_kmer(input logic [W-1:0] s0, input logic [W-1:0] s1,
                             input logic [W-1:0] s2, input logic [W-1:0] s3,
                             input logic last);
        send_beat(2'd0, s0, 1'b0);
        send_beat(2'd1, s1, 1'b0);
        send_beat(2'd2, s2, 1'b0);
        send_beat(2'd3, s3, last);
    endtask

    // Expects the result stream to be live now; consumes all four beats.
    task automatic collect(input string name, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input logic [W-1:0] e2,
                           input logic [W-1:0] e3);
        logic [W-1:0] exp_v [4];
        exp_v[0] = e0;
        exp_v[1] = e1;
        exp_v[2] = e2;
        exp_v[3] = e3;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_min !== exp_v[i] ||
                out_hash_idx !== IB'(i) || out_last !== (i == N - 1) ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d: valid=%b min=%h idx=%0d last=%b rdy=%b, want 1 %h %0d %b 0",
                         name, i, out_valid, out_min, out_hash_idx, out_last,
                         in_ready, exp_v[i], i, (i == N - 1));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s done: valid=%b rdy=%b, want 0 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || idx_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b valid=%b err=%b, want 1 0 0",
                     in_ready, out_valid, idx_err);
        end
    endtask

    task automatic test_single_kmer();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: valid=%b, want 0", out_valid);
        end
        send_kmer(32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        collect("single", 32'h10, 32'h20, 32'h30, 32'h40);
    endtask

    task automatic test_three_kmer_min();
        send_beat(2'd0, 32'hAB1020C5, 1'b0);
        // in_last on a non-final index must not end the sequence.
        send_beat(2'd1, 32'h7, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_last: rdy=%b valid=%b, want 1 0",
                     in_ready, out_valid);
        end
        send_beat(2'd2, 32'h7, 1'b0);
        send_beat(2'd3, 32'h7, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_last: valid=%b rdy=%b, want 0 1",
                     out_valid, in_ready);
        end
        send_kmer(32'h00000005, 32'h7, 32'h7, 32'h7, 1'b0);
        send_kmer(32'hFFFFFFFF, 32'h7, 32'h7, 32'h7, 1'b1);
        collect("three_kmer", 32'h5, 32'h7, 32'h7, 32'h7);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_kmer(32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid     = 1'b1;
            in_hash_idx  = 2'd0;
            in_signature = 32'h0;
            in_last      = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_min !== 32'hA1 ||
                out_hash_idx !== 2'd0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure c%0d: valid=%b min=%h idx=%0d rdy=%b, want 1 a1 0 0",
                         i, out_valid, out_min, out_hash_idx, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect("backpressure", 32'hA1, 32'hB2, 32'hC3, 32'hD4);
        // The ignored beats must not have advanced the index tracker.
        send_kmer(32'h9, 32'h8, 32'h7, 32'h6, 1'b1);
        collect("after_bp", 32'h9, 32'h8, 32'h7, 32'h6);
    endtask

    task automatic test_order_err();
        send_kmer(32'h100, 32'h200, 32'h300, 32'h400, 1'b0);
        send_beat(2'd0, 32'h150, 1'b0);
        checks++;
        if (idx_err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: err=%b, want 0", idx_err);
        end
        send_beat(2'd2, 32'h1, 1'b0);
        checks++;
        if (idx_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, want 1", idx_err);
        end
        send_beat(2'd1, 32'h250, 1'b0);
        send_beat(2'd2, 32'h350, 1'b0);
        send_beat(2'd3, 32'h450, 1'b1);
        collect("order_err", 32'h100, 32'h200, 32'h300, 32'h400);
        checks++;
        if (idx_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, want 1", idx_err);
        end
    endtask

    task automatic test_reset_mid_dump();
        send_kmer(32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_hash_idx !== IB'(i)) begin
                errors++;
                $display("FAIL pre_rst beat%0d: valid=%b idx=%0d, want 1 %0d",
                         i, out_valid, out_hash_idx, i);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || idx_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_dump: valid=%b rdy=%b err=%b, want 0 1 0",
                     out_valid, in_ready, idx_err);
        end
        send_kmer(32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
        collect("post_rst", 32'h1, 32'h2, 32'h3, 32'h4);
    endtask

    task automatic test_back_to_back();
        send_kmer(32'h5, 32'h6, 32'h7, 32'h8, 1'b1);
        collect("b2b_first", 32'h5, 32'h6, 32'h7, 32'h8);
        send_kmer(32'h50, 32'h60, 32'h70, 32'h80, 1'b1);
        collect("b2b_second", 32'h50, 32'h60, 32'h70, 32'h80);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_signature = '0;
        in_hash_idx  = '0;
        in_last      = 1'b0;
        out_ready    = 1'b1;
        test_reset();
        test_single_kmer();
        test_three_kmer_min();
        test_backpressure();
        test_order_err();
        test_reset_mid_dump();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
